// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
// Bus bundle between the instruction fetch unit, the instruction memory port
// and the downstream instruction fifo.
//   imem_req_valid/ready/addr : fetch request handshake (fetch unit -> memory)
//   imem_rsp_valid/data/err   : in-order fetch responses (memory -> fetch unit)
//   fifo_full/wr_en/din       : push port into the instruction fifo,
//                               din = {err, pc, inst}
// master modport = fetch unit side, slave modport = memory/fifo side.
// ---------------------------------------------------------------------------
interface ifu_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                             imem_req_valid;
   logic                             imem_req_ready;
   logic [ADDR_WIDTH-1:0]            imem_req_addr;
   logic                             imem_rsp_valid;
   logic [INST_WIDTH-1:0]            imem_rsp_data;
   logic                             imem_rsp_err;
   logic                             fifo_full;
   logic                             fifo_wr_en;
   logic [ADDR_WIDTH+INST_WIDTH:0]   fifo_din;

   modport master (
      output imem_req_valid, imem_req_addr, fifo_wr_en, fifo_din,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, fifo_full
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, fifo_wr_en, fifo_din,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, fifo_full
   );
endinterface

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch front-end: generates sequential word-aligned PCs, issues
// requests to the instruction memory, pairs each in-order response with its
// PC and pushes {err, pc, inst} into the downstream instruction fifo.
// A redirect restarts fetch at a new PC and discards every response that
// belongs to a request issued before it.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   fetch_en     : allows new requests; in-flight traffic always completes
//   redirect     : one-cycle pulse, restart fetch at redirect_pc (bits [1:0]
//                  ignored)
//   bus (master) : memory request/response and fifo push signals
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
   parameter int                    MAX_OUT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   ifu_fetch_if.master           bus
);

   localparam int         FW       = 1 + ADDR_WIDTH + INST_WIDTH;
   localparam logic [2:0] MAX_C    = 3'(MAX_OUT);
   localparam logic [1:0] PTR_LAST = 2'(MAX_OUT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // Circular pointer advance over the MAX_OUT used slots.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      if (p == PTR_LAST) begin
         ptr_inc = 2'd0;
      end else begin
         ptr_inc = p + 2'd1;
      end
   endfunction

   state_t                state_r;
   logic                  req_valid_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [2:0]            out_cnt_r;
   logic [2:0]            buf_cnt_r;
   logic [2:0]            drop_cnt_r;
   logic                  pend_stale_r;

   // pc of every accepted request, popped by its response
   logic [ADDR_WIDTH-1:0] tag_q_r [4];
   logic [1:0]            tag_wr_r;
   logic [1:0]            tag_rd_r;

   // live responses waiting for room in the downstream fifo
   logic [FW-1:0]         buf_q_r [4];
   logic [1:0]            buf_wr_r;
   logic [1:0]            buf_rd_r;

   logic                  acc_s;
   logic                  rsp_take_s;
   logic                  rsp_live_s;
   logic                  drop_hit_s;
   logic                  push_s;
   logic                  issue_ok_s;
   logic [2:0]            out_nx_s;
   logic [2:0]            buf_nx_s;
   logic [2:0]            drop_nx_s;
   logic                  pend_nx_s;
   logic [ADDR_WIDTH-1:0] pc_nx_s;

   assign acc_s      = req_valid_r & bus.imem_req_ready;
   // A response with nothing outstanding can only be left over from before
   // reset and is ignored.
   assign rsp_take_s = bus.imem_rsp_valid & (out_cnt_r != 3'd0);
   assign drop_hit_s = rsp_take_s & (drop_cnt_r != 3'd0);
   assign rsp_live_s = rsp_take_s & (drop_cnt_r == 3'd0) & ~redirect;
   assign push_s     = (buf_cnt_r != 3'd0) & ~bus.fifo_full & ~redirect;
   // Counting this cycle's accept keeps out_cnt+buf_cnt <= MAX_OUT even when
   // the next request is chained back-to-back.
   assign issue_ok_s = fetch_en & ~redirect &
                       ((out_cnt_r + buf_cnt_r + {2'b00, acc_s}) < MAX_C);
   assign out_nx_s   = out_cnt_r + {2'b00, acc_s} - {2'b00, rsp_take_s};
   assign buf_nx_s   = redirect ? 3'd0
                                : (buf_cnt_r + {2'b00, rsp_live_s} - {2'b00, push_s});

   assign bus.imem_req_valid = req_valid_r;
   assign bus.imem_req_addr  = addr_r;
   assign bus.fifo_wr_en     = push_s;
   assign bus.fifo_din       = buf_q_r[buf_rd_r];

   // Next pc and stale-response bookkeeping.
   always_comb begin
      pc_nx_s   = pc_r;
      drop_nx_s = drop_cnt_r;
      pend_nx_s = pend_stale_r;
      if (redirect) begin
         pc_nx_s   = redirect_pc & ~ADDR_WIDTH'(32'd3);
         // everything in flight after this cycle's accept/response is stale
         drop_nx_s = out_nx_s;
         pend_nx_s = req_valid_r & ~acc_s;
      end else begin
         // a stale pending request carries the old address, so its accept
         // must not advance the already-redirected pc
         if (acc_s && !pend_stale_r) begin
            pc_nx_s = pc_r + ADDR_WIDTH'(32'd4);
         end else begin
            pc_nx_s = pc_r;
         end
         drop_nx_s = drop_cnt_r - {2'b00, drop_hit_s} + {2'b00, acc_s & pend_stale_r};
         pend_nx_s = pend_stale_r & ~acc_s;
      end
   end

   // Request FSM: holds address/valid stable until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         req_valid_r <= 1'b0;
         addr_r      <= RESET_PC;
         pc_r        <= RESET_PC;
      end else begin
         pc_r <= pc_nx_s;
         case (state_r)
            IDLE: begin
               if (issue_ok_s) begin
                  state_r     <= REQ;
                  req_valid_r <= 1'b1;
                  addr_r      <= pc_r;
               end
            end
            REQ: begin
               if (acc_s) begin
                  if (issue_ok_s) begin
                     addr_r <= pc_nx_s;
                  end else begin
                     state_r     <= IDLE;
                     req_valid_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               req_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding, buffered and to-be-dropped response counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt_r    <= 3'd0;
         buf_cnt_r    <= 3'd0;
         drop_cnt_r   <= 3'd0;
         pend_stale_r <= 1'b0;
      end else begin
         out_cnt_r    <= out_nx_s;
         buf_cnt_r    <= buf_nx_s;
         drop_cnt_r   <= drop_nx_s;
         pend_stale_r <= pend_nx_s;
      end
   end

   // Request pc tag queue and response buffer storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            tag_q_r[i] <= {ADDR_WIDTH{1'b0}};
            buf_q_r[i] <= {FW{1'b0}};
         end
         tag_wr_r <= 2'd0;
         tag_rd_r <= 2'd0;
         buf_wr_r <= 2'd0;
         buf_rd_r <= 2'd0;
      end else begin
         if (acc_s) begin
            tag_q_r[tag_wr_r] <= addr_r;
            tag_wr_r          <= ptr_inc(tag_wr_r);
         end
         if (rsp_take_s) begin
            tag_rd_r <= ptr_inc(tag_rd_r);
         end
         if (redirect) begin
            buf_wr_r <= 2'd0;
            buf_rd_r <= 2'd0;
         end else begin
            if (rsp_live_s) begin
               buf_q_r[buf_wr_r] <= {bus.imem_rsp_err, tag_q_r[tag_rd_r], bus.imem_rsp_data};
               buf_wr_r          <= ptr_inc(buf_wr_r);
            end
            if (push_s) begin
               buf_rd_r <= ptr_inc(buf_rd_r);
            end
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
// Directed bench for ifu_fetch. A memory responder answers accepted requests
// after rsp_lat cycles with data = addr ^ FFFF_FFFF; a scoreboard queue gets
// the expected {err, pc, inst} when a live response is driven and is popped
// when the DUT pushes into the fifo. A redirect epoch counter decides which
// responses are stale.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          due;
   } fl_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        redirect;
   logic [31:0] redirect_pc;

   int          total = 0;
   int          bad   = 0;
   int          cyc_n = 0;
   int          rsp_lat = 1;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'd0;

   fl_t         inflight[$];
   logic [64:0] sb_q[$];
   logic [64:0] push_log[$];
   int          push_cyc[$];
   logic [31:0] acc_log[$];

   int          epoch = 0;
   int          req_ep = 0;
   int          rsp_ep_cur = 0;
   logic [31:0] rsp_addr_cur = 32'd0;
   logic [31:0] exp_addr = RST_PC;
   logic        prev_valid = 1'b0;
   logic        prev_acc = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   ifu_fetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

   ifu_fetch #(
      .ADDR_WIDTH (32),
      .INST_WIDTH (32),
      .RESET_PC   (RST_PC),
      .MAX_OUT    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_en    (fetch_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] push_at(input int i);
      if (i < push_log.size()) return push_log[i];
      return {65{1'bx}};
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_log.size()) return acc_log[i];
      return {32{1'bx}};
   endfunction

   function automatic logic [64:0] entry(input logic err, input logic [31:0] pc);
      return {err, pc, pc ^ 32'hFFFF_FFFF};
   endfunction

   // Memory responder plus fifo-side monitor/scoreboard.
   initial begin : monitor
      fl_t         f;
      logic [64:0] e;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.imem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         cyc_n++;
         if (!rst && inflight.size() != 0 && inflight[0].due <= cyc_n) begin
            f = inflight.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = f.addr ^ 32'hFFFF_FFFF;
            bus.imem_rsp_err   = err_en && (f.addr == err_addr);
            rsp_addr_cur       = f.addr;
            rsp_ep_cur         = f.ep;
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'd0;
            bus.imem_rsp_err   = 1'b0;
         end
         #2;
         if (rst) begin
            sb_q.delete();
            inflight.delete();
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            exp_addr   = RST_PC;
            epoch++;
         end else begin
            if (bus.fifo_wr_en) begin
               check("wr_while_full", 65'(bus.fifo_full), 65'd0);
               check("sb_has_entry", 65'(sb_q.size() != 0), 65'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("fifo_din", bus.fifo_din, e);
               end
               push_log.push_back(bus.fifo_din);
               push_cyc.push_back(cyc_n);
            end
            if (bus.imem_rsp_valid && rsp_ep_cur == epoch && !redirect) begin
               sb_q.push_back({bus.imem_rsp_err, rsp_addr_cur, bus.imem_rsp_data});
            end
            if (prev_valid && !prev_acc) begin
               check("req_hold_valid", 65'(bus.imem_req_valid), 65'd1);
            end
            if (bus.imem_req_valid) begin
               if (!prev_valid || prev_acc) begin
                  req_ep = epoch;
                  check("req_addr", 65'(bus.imem_req_addr), 65'(exp_addr));
               end else begin
                  check("req_hold_addr", 65'(bus.imem_req_addr), 65'(prev_addr));
               end
               if (bus.imem_req_ready) begin
                  inflight.push_back('{addr: bus.imem_req_addr, ep: req_ep, due: cyc_n + rsp_lat});
                  acc_log.push_back(bus.imem_req_addr);
                  if (req_ep == epoch) exp_addr = exp_addr + 32'd4;
               end
            end
            prev_valid = bus.imem_req_valid;
            prev_acc   = bus.imem_req_valid && bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
            if (redirect) begin
               sb_q.delete();
               epoch++;
               exp_addr = {redirect_pc[31:2], 2'b00};
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      push_log.delete();
      push_cyc.delete();
      acc_log.delete();
      rst = 1'b0;
   endtask

   task automatic wait_pushes(input int n);
      int k = 0;
      while (push_log.size() < n && k < 80) begin
         cyc(1);
         k++;
      end
   endtask

   task automatic wait_accs(input int n);
      int k = 0;
      while (acc_log.size() < n && k < 80) begin
         cyc(1);
         k++;
      end
   endtask

   task automatic drain();
      fetch_en = 1'b0;
      cyc(rsp_lat + 8);
   endtask

   // Directed test sequence.
   initial begin
      int k;
      rst         = 1'b1;
      fetch_en    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      bus.imem_req_ready = 1'b1;
      bus.fifo_full      = 1'b0;
      cyc(2);
      #1;
      check("rst_req_valid", 65'(bus.imem_req_valid), 65'd0);
      check("rst_wr_en", 65'(bus.fifo_wr_en), 65'd0);
      check("rst_din", bus.fifo_din, 65'd0);

      // sequential fetch
      do_reset();
      fetch_en = 1'b1;
      wait_pushes(3);
      fetch_en = 1'b0;
      check("seq_push0", push_at(0), entry(1'b0, 32'h8000_0000));
      check("seq_push1", push_at(1), entry(1'b0, 32'h8000_0004));
      check("seq_push2", push_at(2), entry(1'b0, 32'h8000_0008));
      drain();

      // fifo full back-pressure
      do_reset();
      bus.fifo_full = 1'b1;
      fetch_en      = 1'b1;
      cyc(20);
      check("full_req_count", 65'(acc_log.size()), 65'd2);
      check("full_no_push", 65'(push_log.size()), 65'd0);
      check("full_idle", 65'(bus.imem_req_valid), 65'd0);
      bus.fifo_full = 1'b0;
      wait_pushes(2);
      check("full_rel_push0", push_at(0), entry(1'b0, 32'h8000_0000));
      check("full_rel_push1", push_at(1), entry(1'b0, 32'h8000_0004));
      check("full_rel_consec", 65'(push_cyc.size() >= 2 && push_cyc[1] - push_cyc[0] == 1), 65'd1);
      wait_accs(3);
      check("full_resume_addr", 65'(acc_at(2)), 65'h8000_0008);
      drain();

      // redirect with two requests in flight
      rsp_lat = 4;
      do_reset();
      fetch_en = 1'b1;
      wait_accs(2);
      check("rd2_no_push_yet", 65'(push_log.size()), 65'd0);
      redirect_pc = 32'h8000_0102;
      redirect    = 1'b1;
      cyc(1);
      redirect = 1'b0;
      wait_pushes(1);
      fetch_en = 1'b0;
      check("rd2_next_addr", 65'(acc_at(2)), 65'h8000_0100);
      check("rd2_first_push", push_at(0), entry(1'b0, 32'h8000_0100));
      drain();
      rsp_lat = 1;

      // redirect while a request is stalled
      do_reset();
      bus.imem_req_ready = 1'b0;
      fetch_en = 1'b1;
      cyc(3);
      redirect_pc = 32'h8000_0200;
      redirect    = 1'b1;
      #1;
      check("stall_valid0", 65'(bus.imem_req_valid), 65'd1);
      check("stall_addr0", 65'(bus.imem_req_addr), 65'h8000_0000);
      cyc(1);
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("stall_addr", 65'(bus.imem_req_addr), 65'h8000_0000);
         cyc(1);
      end
      bus.imem_req_ready = 1'b1;
      wait_pushes(1);
      fetch_en = 1'b0;
      check("stall_acc0", 65'(acc_at(0)), 65'h8000_0000);
      check("stall_acc1", 65'(acc_at(1)), 65'h8000_0200);
      check("stall_first_push", push_at(0), entry(1'b0, 32'h8000_0200));
      drain();

      // error response
      do_reset();
      err_en   = 1'b1;
      err_addr = 32'h8000_0004;
      fetch_en = 1'b1;
      wait_pushes(3);
      fetch_en = 1'b0;
      check("err_push0", push_at(0), entry(1'b0, 32'h8000_0000));
      check("err_push1", push_at(1), entry(1'b1, 32'h8000_0004));
      check("err_push2", push_at(2), entry(1'b0, 32'h8000_0008));
      drain();
      err_en = 1'b0;

      // asynchronous reset with an entry buffered
      do_reset();
      bus.fifo_full = 1'b1;
      fetch_en      = 1'b1;
      k = 0;
      while (sb_q.size() < 1 && k < 40) begin
         cyc(1);
         k++;
      end
      check("ar_buffered", 65'(sb_q.size()), 65'd1);
      #1;
      rst = 1'b1;
      #1;
      check("ar_req_valid", 65'(bus.imem_req_valid), 65'd0);
      check("ar_wr_en", 65'(bus.fifo_wr_en), 65'd0);
      check("ar_din", bus.fifo_din, 65'd0);
      push_log.delete();
      push_cyc.delete();
      acc_log.delete();
      cyc(1);
      rst = 1'b0;
      bus.fifo_full = 1'b0;
      wait_pushes(1);
      fetch_en = 1'b0;
      check("ar_first_acc", 65'(acc_at(0)), 65'h8000_0000);
      check("ar_first_push", push_at(0), entry(1'b0, 32'h8000_0000));
      drain();

      check("sb_empty_end", 65'(sb_q.size()), 65'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch front-end of the riscv-cpu core. It generates sequential PCs, issues read requests to the instruction memory port, and collects responses. It pushes {err, pc, inst} entries into the downstream instruction fifo (FIFO_WIDTH = 1+ADDR_WIDTH+INST_WIDTH) through that fifo's wr_en/din/full interface. It handles branch redirects by discarding stale in-flight responses; flushing the fifo itself is outside this block.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
ADDR_WIDTH, 32, PC/address width
INST_WIDTH, 32, instruction width
MAX_OUT, 2, max requests in flight plus entries held in the response buffer (1..3)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
fetch_en  input  1  when 0, no new request is issued; in-flight traffic completes
redirect  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] forced to 0
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address
imem_rsp_valid  input  1  response valid; always accepted, in request order
imem_rsp_data  input  INST_WIDTH  instruction word
imem_rsp_err  input  1  access fault for this response
fifo_full  input  1  downstream fifo full
fifo_wr_en  output  1  push to fifo
fifo_din  output  1+ADDR_WIDTH+INST_WIDTH  {err, pc, inst}

Behaviour:
- Reset (async, any time): pc=RESET_PC, FSM=IDLE, out_cnt=0, buf_cnt=0, drop_cnt=0, pend_stale=0, imem_req_valid=0, fifo_wr_en=0, fifo_din=0. In-flight traffic is forgotten; responses arriving after reset release count as live only if issued after reset.
- FSM IDLE: imem_req_valid=0. Go to REQ when fetch_en && !redirect && (out_cnt+buf_cnt < MAX_OUT). imem_req_addr latches pc.
- FSM REQ: imem_req_valid=1. imem_req_addr and valid stay stable until imem_req_ready, regardless of fetch_en or redirect. On accept: out_cnt+1 and pc+=4 (wraps modulo 2^ADDR_WIDTH). Go to REQ again (back-to-back, new addr) if the issue condition still holds, else IDLE.
- Request tag: each accepted request records in a MAX_OUT-deep pc queue, so every response pairs with its pc.
- Response: out_cnt-1. If drop_cnt>0, drop_cnt-1 and discard. Else write {err, pc, data} into the response buffer (MAX_OUT deep, FIFO order), buf_cnt+1.
- Push: fifo_wr_en = (buf_cnt!=0) && !fifo_full && !redirect. fifo_din = buffer head, pop on push. Minimum latency: response at cycle t gives fifo_wr_en at t+1.
- Simultaneous push and response: both apply, buf_cnt unchanged.
- Invariant: out_cnt+buf_cnt <= MAX_OUT, so the buffer never overflows with fifo full indefinitely.
- Redirect (cycle t):
  - pc <= redirect_pc & ~3.
  - Response buffer cleared; a response in cycle t is discarded.
  - drop_cnt <= out_cnt after cycle t's accept and response (all in flight are stale).
  - If a request is pending and not accepted at t, pend_stale=1; when it is accepted, drop_cnt+1 and pend_stale=0. The next request uses the new pc.
  - Back-to-back redirects: the last wins, and drop counting accumulates correctly.
- Redirect priority over fetch_en. Error responses are pushed like normal ones; fetch continues.

Test Plan:
- Reset, fetch_en=1, ready=1, rsp one cycle after accept with data=addr^32'hFFFF_FFFF -> fifo sees pcs 8000_0000, 8000_0004, 8000_0008 in order with matching data, err=0.
- fifo_full=1 held 20 cycles -> at most MAX_OUT=2 requests issued, buf_cnt=2, no wr_en. Release -> two pushes on consecutive cycles, then fetch resumes at 8000_0008.
- Two requests in flight, redirect to 8000_0102 -> both responses dropped; next request addr 8000_0100; first pushed entry pc=8000_0100.
- Redirect while imem_req_valid=1 and ready=0 for 3 cycles -> addr stays old until accept. That response is dropped; the following request is at the redirect target.
- rsp_err=1 on pc 8000_0004 -> entry {1, 8000_0004, data} pushed; the next entry is 8000_0008.
- Assert rst mid-flight with buf_cnt=1 -> outputs 0 immediately (async). After release, first request addr=8000_0000.
